// File: rtl/sram_port_ctrl.sv
// sram_port_ctrl: valid/ready request front-end for a single-port SRAM macro
// (active-low CEB/WEB, registered Q, 1-cycle read latency). Read data is
// captured into a 2-entry response FIFO with valid/ready backpressure.
// Optional build macro SRAM_PORT_CTRL_CLEAR_EN: after reset, sweep the whole
// array writing zeros before accepting any request (busy=1 while sweeping).

module sram_port_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              sram_ceb,
  output logic              sram_web,
  output logic [ADDR_W-1:0] sram_a,
  output logic [DATA_W-1:0] sram_d,
  input  logic [DATA_W-1:0] sram_q,
  output logic              busy
);

  logic [DATA_W-1:0] fifo_mem_r [2];
  logic              wr_ptr_r;
  logic              rd_ptr_r;
  logic [1:0]        count_r;
  logic              inflight_r;
  logic              fire_s;
  logic              push_s;
  logic              pop_s;
  logic              busy_s;
  logic [ADDR_W-1:0] clear_addr_s;
  logic [2:0]        credit_used_s;

`ifdef SRAM_PORT_CTRL_CLEAR_EN
  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [ADDR_W-1:0] clear_addr_r;
  logic [ADDR_W-1:0] clear_addr_nxt_s;

  // State register: any reset (re)starts the clear sweep from address 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= ST_CLEAR;
      clear_addr_r <= {ADDR_W{1'b0}};
    end else begin
      state_r      <= state_nxt_s;
      clear_addr_r <= clear_addr_nxt_s;
    end
  end

  // Next state: write every address exactly once, then hand the port over.
  always_comb begin
    state_nxt_s      = state_r;
    clear_addr_nxt_s = clear_addr_r;
    case (state_r)
      ST_CLEAR: begin
        clear_addr_nxt_s = clear_addr_r + ADDR_W'(1);
        if (clear_addr_r == ADDR_W'(DEPTH - 1)) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_CLEAR;
        end
      end
      ST_RUN: begin
        state_nxt_s = ST_RUN;
      end
      default: begin
        state_nxt_s      = ST_CLEAR;
        clear_addr_nxt_s = {ADDR_W{1'b0}};
      end
    endcase
  end

  assign busy_s       = (state_r == ST_CLEAR);
  assign clear_addr_s = clear_addr_r;
`else
  assign busy_s       = 1'b0;
  assign clear_addr_s = {ADDR_W{1'b0}};
`endif

  // Credits: FIFO entries plus the read still in the macro pipeline, minus
  // the entry leaving this cycle. Two credits cover the 2-entry FIFO, so a
  // read can be issued every cycle while the consumer keeps up.
  assign resp_valid    = (count_r != 2'd0);
  assign pop_s         = resp_valid && resp_ready;
  assign credit_used_s = {1'b0, count_r} + {2'b00, inflight_r} - {2'b00, pop_s};
  assign req_ready     = !busy_s && (credit_used_s < 3'd2);
  assign fire_s        = req_valid && req_ready;
  assign push_s        = inflight_r;
  assign resp_rdata    = fifo_mem_r[rd_ptr_r];
  assign busy          = busy_s;

  // Macro strobes: clear sweep has priority, otherwise follow the accepted request.
  always_comb begin
    sram_ceb = 1'b1;
    sram_web = 1'b1;
    sram_a   = {ADDR_W{1'b0}};
    sram_d   = {DATA_W{1'b0}};
    if (busy_s) begin
      sram_ceb = 1'b0;
      sram_web = 1'b0;
      sram_a   = clear_addr_s;
      sram_d   = {DATA_W{1'b0}};
    end else if (fire_s) begin
      sram_ceb = 1'b0;
      sram_web = !req_write;
      sram_a   = req_addr;
      sram_d   = req_wdata;
    end else begin
      sram_ceb = 1'b1;
      sram_web = 1'b1;
      sram_a   = {ADDR_W{1'b0}};
      sram_d   = {DATA_W{1'b0}};
    end
  end

  // Read tracking: Q is only meaningful in the cycle after a read is accepted.
  always_ff @(posedge clock) begin
    if (reset) begin
      inflight_r <= 1'b0;
    end else begin
      inflight_r <= fire_s && !req_write;
    end
  end

  // Response FIFO pointers and occupancy; reset flushes any pending data.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= !wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= !rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  // FIFO storage: entries are only observed while counted, so no reset needed.
  always_ff @(posedge clock) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= sram_q;
    end
  end

  // Checks: the credit rule must make a push into a full FIFO impossible.
  a_no_overflow: assert property (@(posedge clock) disable iff (reset)
                                  !(push_s && !pop_s && (count_r == 2'd2)));
  a_count_range: assert property (@(posedge clock) disable iff (reset)
                                  (count_r <= 2'd2));
  a_depth_match: assert property (@(posedge clock) (DEPTH == (1 << ADDR_W)));

endmodule

// File: tb/tb_sram_port_ctrl.sv
// Self-checking bench for sram_port_ctrl with a behavioural SRAM macro and a
// transaction-level reference model (memory array + response queue).
module tb_sram_port_ctrl;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 6;
  localparam int DEPTH  = 64;

  logic              clock = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              sram_ceb;
  logic              sram_web;
  logic [ADDR_W-1:0] sram_a;
  logic [DATA_W-1:0] sram_d;
  logic [DATA_W-1:0] sram_q;
  logic              busy;

  sram_port_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .sram_ceb(sram_ceb), .sram_web(sram_web), .sram_a(sram_a), .sram_d(sram_d),
    .sram_q(sram_q), .busy(busy)
  );

  always #5 clock = ~clock;

  // Behavioural single-port SRAM macro: registered Q, 1-cycle read latency.
  logic [DATA_W-1:0] macro_mem [DEPTH];
  always @(posedge clock) begin
    if (!sram_ceb) begin
      if (!sram_web) macro_mem[sram_a] <= sram_d;
      else sram_q <= macro_mem[sram_a];
    end
  end

  // Reference model: word array plus queue of pending read responses.
  typedef struct { logic [7:0] data; int due; } resp_t;
  logic [7:0] ref_mem [DEPTH];
  resp_t      ref_q [$];
  int         cyc = 0;
  bit         exp_ready, exp_valid, exp_fire, exp_pop;
  logic [7:0] exp_data;
  int         checks = 0;
  int         errors = 0;

  // Drive one cycle's inputs and predict the cycle's observable behaviour.
  task automatic step(input bit v, input bit w, input logic [5:0] a,
                      input logic [7:0] d, input bit rr);
    @(posedge clock); #1;
    req_valid = v; req_write = w; req_addr = a; req_wdata = d; resp_ready = rr;
    exp_valid = (ref_q.size() > 0) && (ref_q[0].due <= cyc);
    exp_data  = exp_valid ? ref_q[0].data : 8'h00;
    exp_pop   = exp_valid && rr;
    exp_ready = (ref_q.size() - int'(exp_pop)) < 2;
    exp_fire  = v && exp_ready;
    @(negedge clock);
  endtask

  // Apply the cycle's effects to the model (happens at the next clock edge).
  task automatic commit();
    if (exp_pop) void'(ref_q.pop_front());
    if (exp_fire) begin
      if (req_write) ref_mem[req_addr] = req_wdata;
      else ref_q.push_back('{ref_mem[req_addr], cyc + 2});
    end
    cyc++;
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; resp_ready = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    ref_q.delete();
`ifdef SRAM_PORT_CTRL_CLEAR_EN
    repeat (DEPTH - 1) @(posedge clock);
    for (int k = 0; k < DEPTH; k++) ref_mem[k] = 8'h00;
`endif
  endtask

  task automatic test_reset();
    @(posedge clock); #1;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; resp_ready = 1'b0;
    req_addr = 6'd0; req_wdata = 8'h00;
    @(posedge clock); #1;
    reset = 1'b0;
    ref_q.delete();
    @(negedge clock);
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
`ifdef SRAM_PORT_CTRL_CLEAR_EN
    for (int k = 0; k < DEPTH; k++) begin
      if (k > 0) @(negedge clock);
      checks++; if (busy !== 1'b1 || req_ready !== 1'b0) begin errors++; $display("FAIL clear_busy k=%0d busy=%b ready=%b exp 1/0", k, busy, req_ready); end
      checks++; if (sram_ceb !== 1'b0 || sram_web !== 1'b0 || sram_a !== 6'(k) || sram_d !== 8'h00) begin
        errors++; $display("FAIL clear_write k=%0d ceb=%b web=%b a=%0d d=%h exp 0/0/%0d/00", k, sram_ceb, sram_web, sram_a, sram_d, k);
      end
    end
    @(negedge clock);
    checks++; if (busy !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL clear_done busy=%b ready=%b exp 0/1", busy, req_ready); end
    for (int k = 0; k < DEPTH; k++) ref_mem[k] = 8'h00;
    for (int i = 0; i < 4; i++) begin
      step(i == 0, 1'b0, 6'd63, 8'h00, 1'b1);
      checks++; if (resp_valid !== exp_valid) begin errors++; $display("FAIL clear_rd63_valid i=%0d got=%b exp=%b", i, resp_valid, exp_valid); end
      if (exp_valid) begin
        checks++; if (resp_rdata !== 8'h00) begin errors++; $display("FAIL clear_rd63_data got=%h exp=00", resp_rdata); end
      end
      commit();
    end
`else
    checks++; if (busy !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready busy=%b ready=%b exp 0/1", busy, req_ready); end
    checks++; if (sram_ceb !== 1'b1 || sram_web !== 1'b1) begin errors++; $display("FAIL reset_strobes ceb=%b web=%b exp 1/1", sram_ceb, sram_web); end
`endif
  endtask

  task automatic test_write_read();
    int first_valid;
    first_valid = -1;
    step(1'b1, 1'b1, 6'd3, 8'hA5, 1'b1);
    checks++; if (sram_ceb !== 1'b0 || sram_web !== 1'b0 || sram_a !== 6'd3 || sram_d !== 8'hA5) begin
      errors++; $display("FAIL wr_strobes ceb=%b web=%b a=%0d d=%h exp 0/0/3/a5", sram_ceb, sram_web, sram_a, sram_d);
    end
    commit();
    step(1'b1, 1'b0, 6'd3, 8'h00, 1'b1);
    checks++; if (sram_ceb !== 1'b0 || sram_web !== 1'b1 || sram_a !== 6'd3) begin
      errors++; $display("FAIL rd_strobes ceb=%b web=%b a=%0d exp 0/1/3", sram_ceb, sram_web, sram_a);
    end
    commit();
    for (int i = 1; i <= 3; i++) begin
      step(1'b0, 1'b0, 6'd0, 8'h00, 1'b1);
      if (resp_valid === 1'b1 && first_valid < 0) begin
        first_valid = i;
        checks++; if (resp_rdata !== 8'hA5) begin errors++; $display("FAIL wr_rd_data got=%h exp=a5", resp_rdata); end
      end
      commit();
    end
    checks++; if (first_valid != 2) begin errors++; $display("FAIL wr_rd_latency got=%0d exp=2", first_valid); end
  endtask

  task automatic test_back_to_back();
    int got;
    got = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 6'(i), 8'(i) ^ 8'h3C, 1'b1);
      commit();
    end
    for (int i = 0; i < 10; i++) begin
      step(i < 8, 1'b0, 6'(i), 8'h00, 1'b1);
      if (i < 8) begin
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready i=%0d got=%b exp=1", i, req_ready); end
      end
      checks++; if (resp_valid !== exp_valid) begin errors++; $display("FAIL b2b_valid i=%0d got=%b exp=%b", i, resp_valid, exp_valid); end
      if (resp_valid === 1'b1) begin
        checks++; if (resp_rdata !== (8'(got) ^ 8'h3C)) begin errors++; $display("FAIL b2b_data n=%0d got=%h exp=%h", got, resp_rdata, 8'(got) ^ 8'h3C); end
        got++;
      end
      commit();
    end
    checks++; if (got != 8) begin errors++; $display("FAIL b2b_count got=%0d exp=8", got); end
  endtask

  task automatic test_backpressure();
    int accepted;
    accepted = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 6'(i % 2), 8'h00, 1'b0);
      checks++; if (req_ready !== exp_ready || sram_ceb !== !exp_fire) begin
        errors++; $display("FAIL bp_ready i=%0d ready=%b ceb=%b exp %b/%b", i, req_ready, sram_ceb, exp_ready, !exp_fire);
      end
      if (exp_valid) begin
        checks++; if (resp_rdata !== 8'h3C) begin errors++; $display("FAIL bp_hold i=%0d got=%h exp=3c", i, resp_rdata); end
      end
      if (sram_ceb === 1'b0) accepted++;
      commit();
    end
    checks++; if (accepted != 2) begin errors++; $display("FAIL bp_accepted got=%0d exp=2", accepted); end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 6'd0, 8'h00, 1'b1);
      checks++; if (resp_valid !== exp_valid) begin errors++; $display("FAIL bp_drain_valid i=%0d got=%b exp=%b", i, resp_valid, exp_valid); end
      if (exp_valid) begin
        checks++; if (resp_rdata !== exp_data) begin errors++; $display("FAIL bp_drain_data i=%0d got=%h exp=%h", i, resp_rdata, exp_data); end
      end
      commit();
    end
    step(1'b0, 1'b0, 6'd0, 8'h00, 1'b1);
    checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("FAIL bp_restore ready=%b valid=%b exp 1/0", req_ready, resp_valid); end
    commit();
  endtask

  task automatic test_reset_midflight();
    step(1'b1, 1'b0, 6'd5, 8'h00, 1'b1);
    commit();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 6'd0, 8'h00, 1'b1);
      checks++; if (resp_valid !== 1'b0 || sram_ceb !== 1'b1 || req_ready !== 1'b1) begin
        errors++; $display("FAIL midrst i=%0d valid=%b ceb=%b ready=%b exp 0/1/1", i, resp_valid, sram_ceb, req_ready);
      end
      commit();
    end
  endtask

  task automatic test_random();
    bit v, w, rr;
    logic [5:0] a;
    logic [7:0] d;
    for (int k = 0; k < DEPTH; k++) begin
      step(1'b1, 1'b1, 6'(k), 8'($urandom), 1'b1);
      commit();
    end
    for (int n = 0; n < 400 + 4; n++) begin
      v  = (n < 400) && ($urandom_range(3) != 0);
      w  = $urandom_range(1) == 1;
      a  = 6'($urandom);
      d  = 8'($urandom);
      rr = (n >= 400) || ($urandom_range(3) != 0);
      step(v, w, a, d, rr);
      checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready n=%0d got=%b exp=%b", n, req_ready, exp_ready); end
      checks++; if (resp_valid !== exp_valid) begin errors++; $display("FAIL rnd_valid n=%0d got=%b exp=%b", n, resp_valid, exp_valid); end
      if (exp_valid) begin
        checks++; if (resp_rdata !== exp_data) begin errors++; $display("FAIL rnd_data n=%0d got=%h exp=%h", n, resp_rdata, exp_data); end
      end
      checks++; if (sram_ceb !== !exp_fire || sram_web !== !(exp_fire && w) || busy !== 1'b0) begin
        errors++; $display("FAIL rnd_strobes n=%0d ceb=%b web=%b busy=%b exp %b/%b/0", n, sram_ceb, sram_web, busy, !exp_fire, !(exp_fire && w));
      end
      if (exp_fire) begin
        checks++; if (sram_a !== a || sram_d !== d) begin errors++; $display("FAIL rnd_addr n=%0d a=%0d d=%h exp %0d/%h", n, sram_a, sram_d, a, d); end
      end
      commit();
    end
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; resp_ready = 1'b0;
    req_addr = 6'd0; req_wdata = 8'h00;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
